axi4_usr_bridge: RTL

Parametrised AXI4 slave that converts full AXI4 bursts into a simple user-side register/memory port with per-byte write strobes. It is the successor to the single-FSM hardware-accelerator bridge: independent read and write channels, correct FIXED/INCR/WRAP address generation, SLVERR decoding, and a read-data FIFO that absorbs RREADY backpressure. It sits between the SoC AXI interconnect and user accelerator logic.

---
 rtl/axi4_usr_bridge_pkg.sv | 24 ++
 rtl/axi4_burst_addr_gen.sv | 31 +++
 rtl/axi4_usr_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_usr_bridge_pkg.sv
// Shared encodings for the AXI4-to-user-port bridge: burst types, response codes
// and the write/read channel state machines.
package axi4_usr_bridge_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_DRAIN
    } rstate_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address for an AXI4 burst. Reserved burst type falls back to INCR.
module axi4_burst_addr_gen
    import axi4_usr_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        bytes       = ADDR_WIDTH'(1) << size_i;
        incr_addr   = addr_i + bytes;
        // Wrap window is the total burst size; only low bits inside it move.
        wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
        next_addr_o = incr_addr;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_usr_bridge.sv
// AXI4 slave bridging full bursts onto a simple user register/memory port, with
// independent read/write channels and a credit-controlled read-data FIFO.
module axi4_usr_bridge
    import axi4_usr_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int ADDR_SPAN     = 4096
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic [ID_WIDTH-1:0]     axi_awid,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [ID_WIDTH-1:0]     axi_arid,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [ID_WIDTH-1:0]     axi_rid,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic                    usr_we,
    output logic [ADDR_WIDTH-1:0]   usr_waddr,
    output logic [DATA_WIDTH-1:0]   usr_wdata,
    output logic [DATA_WIDTH/8-1:0] usr_wstrb,
    output logic                    usr_re,
    output logic [ADDR_WIDTH-1:0]   usr_raddr,
    input  logic [DATA_WIDTH-1:0]   usr_rdata,
    input  logic                    usr_rvalid,
    input  logic                    usr_irq,
    output logic                    axi_interrupt
);

    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic in_span(input logic [ADDR_WIDTH-1:0] a);
        return a < ADDR_WIDTH'(ADDR_SPAN);
    endfunction

    // Beat count governs the burst; WLAST is deliberately not used for control.
    logic unused_wlast;
    assign unused_wlast = axi_wlast;

    wstate_e               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_nxt;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  werr_q, werr_d;

    rstate_e               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d, rpush_q, rpush_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [CNT_W-1:0]      outst_q, outst_d, fcnt_q, fcnt_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  irq_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [RD_FIFO_DEPTH];
    logic [1:0]            fifo_resp_q [RD_FIFO_DEPTH];
    logic                  fifo_last_q [RD_FIFO_DEPTH];

    logic [CNT_W:0]        inflight;
    logic                  credit_ok, rsp_accept, issue, err_push, push, pop, raddr_ok;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            push_resp;
    logic                  push_last;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr_gen (
        .addr_i(waddr_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q),
        .next_addr_o(waddr_nxt)
    );

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr_gen (
        .addr_i(raddr_q), .size_i(rsize_q), .len_i(rlen_q), .burst_i(rburst_q),
        .next_addr_o(raddr_nxt)
    );

    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        usr_we   = 1'b0;
        case (wstate_q)
            W_IDLE: if (axi_awvalid) begin
                wid_d    = axi_awid;
                waddr_d  = axi_awaddr;
                wlen_d   = axi_awlen;
                wcnt_d   = axi_awlen;
                wsize_d  = axi_awsize;
                wburst_d = axi_awburst;
                werr_d   = 1'b0;
                wstate_d = W_DATA;
            end
            W_DATA: if (axi_wvalid) begin
                usr_we  = in_span(waddr_q);
                werr_d  = werr_q | ~in_span(waddr_q);
                waddr_d = waddr_nxt;
                if (wcnt_q == 8'd0) wstate_d = W_RESP;
                else                wcnt_d   = wcnt_q - 8'd1;
            end
            W_RESP: if (axi_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    assign axi_awready = (wstate_q == W_IDLE);
    assign axi_wready  = (wstate_q == W_DATA);
    assign axi_bvalid  = (wstate_q == W_RESP);
    assign axi_bid     = wid_q;
    assign axi_bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
    assign usr_waddr   = waddr_q;
    assign usr_wdata   = axi_wdata;
    assign usr_wstrb   = axi_wstrb;

    // Error beats bypass the user port, so they wait for outstanding reads to
    // return first; otherwise they would overtake earlier data in the FIFO.
    always_comb begin
        inflight   = {1'b0, fcnt_q} + {1'b0, outst_q};
        credit_ok  = inflight < (CNT_W + 1)'(RD_FIFO_DEPTH);
        raddr_ok   = in_span(raddr_q);
        rsp_accept = usr_rvalid && (outst_q != '0);
        issue      = (rstate_q == R_ISSUE) && credit_ok && (raddr_ok || (outst_q == '0));
        usr_re     = issue && raddr_ok;
        err_push   = issue && !raddr_ok;
        push       = rsp_accept || err_push;
        push_data  = err_push ? '0 : usr_rdata;
        push_resp  = err_push ? RESP_SLVERR : RESP_OKAY;
        push_last  = (rpush_q == rlen_q);
        pop        = axi_rvalid && axi_rready;
        outst_d    = outst_q + CNT_W'(usr_re) - CNT_W'(rsp_accept);
        fcnt_d     = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d     = wptr_q + PTR_W'(push);
        rptr_d     = rptr_q + PTR_W'(pop);
        rpush_d    = rpush_q + 8'(push);

        rstate_d = rstate_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        case (rstate_q)
            R_IDLE: if (axi_arvalid) begin
                rid_d    = axi_arid;
                raddr_d  = axi_araddr;
                rlen_d   = axi_arlen;
                rcnt_d   = axi_arlen;
                rsize_d  = axi_arsize;
                rburst_d = axi_arburst;
                rpush_d  = 8'd0;
                rstate_d = R_ISSUE;
            end
            R_ISSUE: if (issue) begin
                raddr_d = raddr_nxt;
                if (rcnt_q == 8'd0) rstate_d = R_DRAIN;
                else                rcnt_d   = rcnt_q - 8'd1;
            end
            R_DRAIN: if (pop && fifo_last_q[rptr_q]) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    assign axi_arready   = (rstate_q == R_IDLE);
    assign usr_raddr     = raddr_q;
    assign axi_rvalid    = (fcnt_q != '0);
    assign axi_rid       = rid_q;
    assign axi_rdata     = fifo_data_q[rptr_q];
    assign axi_rresp     = fifo_resp_q[rptr_q];
    assign axi_rlast     = fifo_last_q[rptr_q];
    assign axi_interrupt = irq_q;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= 8'd0;
            werr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            rcnt_q   <= 8'd0;
            rpush_q  <= 8'd0;
            outst_q  <= '0;
            fcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            rpush_q  <= rpush_d;
            outst_q  <= outst_d;
            fcnt_q   <= fcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            irq_q    <= usr_irq;
        end
    end

    // Burst attributes and FIFO storage are only meaningful under valid control state.
    always_ff @(posedge axi_aclk) begin
        wid_q    <= wid_d;
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
        rid_q    <= rid_d;
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
        if (push) begin
            fifo_data_q[wptr_q] <= push_data;
            fifo_resp_q[wptr_q] <= push_resp;
            fifo_last_q[wptr_q] <= push_last;
        end
    end

endmodule
